writeback_arbiter: RTL and testbench

Single-port writeback arbiter feeding the CPU's register file write port (wAddr/wDin/wEna). It merges same-cycle results from the ALU pipeline, which has priority, with late load/multi-cycle results from the memory side, which are buffered in a small FIFO. A bounded starvation counter guarantees the memory side progresses. The block drives one registered write per cycle and can expose a scoreboard of registers that still have queued writes.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/wb_fifo.sv | 74 +++++++
 rtl/writeback_arbiter.sv | 126 ++++++++++++
 tb/tb_writeback_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for the register-file writeback path.
// One request format serves the ALU offer, the memory offer and the writeback queue entries.
package cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests with count/full/empty; one cycle from push to head.
// Push is ignored when full and pop is ignored when empty; WB_SCOREBOARD_EN exposes per-slot address/valid.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  wb_req_t                     i_push_dat,
    input  logic                        i_pop,
    output wb_req_t                     o_head,
    output logic [CNT_W-1:0]            o_count,
    output logic                        o_full,
    output logic                        o_empty
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [DEPTH-1:0]            o_slot_vld,
    output logic [DEPTH*REG_ADDR_W-1:0] o_slot_addr
`endif
);
    wb_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_en;
    logic             w_pop_en;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_en = i_push && !o_full;
    assign w_pop_en  = i_pop && !o_empty;

    // Payload storage needs no reset: validity comes solely from pointers and count.
    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[r_wr_ptr] <= i_push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WB_SCOREBOARD_EN
    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] w_off;
        o_slot_vld  = '0;
        o_slot_addr = '0;
        w_off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PTR_W'(i) - r_rd_ptr;
            o_slot_vld[i] = ({1'b0, w_off} < r_count);
            o_slot_addr[i*REG_ADDR_W +: REG_ADDR_W] = r_mem[i].addr;
        end
    end
`endif
endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU priority, queued memory results, bounded starvation; 1-cycle registered write.
// alu_stall/mem_ready come from registered state only; WB_SCOREBOARD_EN enables the pending scoreboard.
module writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_stall,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    output logic [REG_ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0]     wDin,
    output logic                  wEna,
    output logic [31:0]           pending
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    wb_req_t               w_alu_req;
    wb_req_t               w_mem_req;
    wb_req_t               w_head;
    wb_req_t               w_sel;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_forced;
    logic                  w_pop;
    logic                  w_alu_take;
    logic                  w_push;
    logic [SC_W-1:0]       r_starve_cnt;
    logic                  r_wena;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]     r_wdin;
`ifdef WB_SCOREBOARD_EN
    logic [FIFO_DEPTH-1:0]            w_slot_vld;
    logic [FIFO_DEPTH*REG_ADDR_W-1:0] w_slot_addr;
`endif

    assign w_alu_req = '{addr: alu_addr, data: alu_data};
    assign w_mem_req = '{addr: mem_addr, data: mem_data};
    assign w_push    = mem_valid && !w_full;
    assign mem_ready = (w_count != CNT_W'(FIFO_DEPTH));

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_mem_req),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
`ifdef WB_SCOREBOARD_EN
        ,
        .o_slot_vld (w_slot_vld),
        .o_slot_addr(w_slot_addr)
`endif
    );

    assign w_forced  = (r_starve_cnt == SC_W'(STARVE_LIMIT)) && !w_empty;
    assign alu_stall = w_forced;

    always_comb begin
        w_pop      = 1'b0;
        w_alu_take = 1'b0;
        w_sel      = w_alu_req;
        if (w_forced) begin
            w_pop = 1'b1;
            w_sel = w_head;
        end else if (alu_valid) begin
            w_alu_take = 1'b1;
        end else if (!w_empty) begin
            w_pop = 1'b1;
            w_sel = w_head;
        end
    end

    // Writes to r0 still consume their slot but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wena  <= 1'b0;
            r_waddr <= '0;
            r_wdin  <= '0;
        end else if ((w_pop || w_alu_take) && (w_sel.addr != '0)) begin
            r_wena  <= 1'b1;
            r_waddr <= w_sel.addr;
            r_wdin  <= w_sel.data;
        end else begin
            r_wena  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != SC_W'(STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign wEna  = r_wena;
    assign wAddr = r_waddr;
    assign wDin  = r_wdin;

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_slot_vld[i]) pending[w_slot_addr[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
        end
    end
`else
    assign pending = 32'b0;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_stall, mem_ready, wEna;
    logic [4:0]  wAddr;
    logic [31:0] wDin;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;
    int n_stall = 0;
    int n_wena  = 0;

    ent_t        q[$];
    int          m_scnt;
    logic        m_wena;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdin;

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_stall(alu_stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wAddr(wAddr), .wDin(wDin), .wEna(wEna), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_forced();
        return (m_scnt == LIMIT) && (q.size() > 0);
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
`ifdef WB_SCOREBOARD_EN
        foreach (q[i]) p[q[i].addr] = 1'b1;
`endif
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        m_scnt  = 0;
        m_wena  = 1'b0;
        m_waddr = '0;
        m_wdin  = '0;
    endtask

    // One clock: drive at the falling edge, check registered-state outputs, then advance the model.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        ent_t        e;
        logic        took;
        logic        popped;
        logic        nonempty;
        logic        n_wena;
        logic [4:0]  n_waddr;
        logic [31:0] n_wdin;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        #1;
        chk("wEna", {31'b0, wEna}, {31'b0, m_wena});
        chk("wAddr", {27'b0, wAddr}, {27'b0, m_waddr});
        chk("wDin", wDin, m_wdin);
        chk("alu_stall", {31'b0, alu_stall}, {31'b0, m_forced()});
        chk("mem_ready", {31'b0, mem_ready}, {31'b0, logic'(q.size() < DEPTH)});
        chk("pending", pending, m_pending());
        if (alu_stall) n_stall++;
        if (wEna) n_wena++;

        nonempty = (q.size() > 0);
        took = 1'b0; popped = 1'b0;
        e = '{addr: aa, data: ad};
        if (m_forced()) begin
            e = q.pop_front(); took = 1'b1; popped = 1'b1;
        end else if (av) begin
            took = 1'b1;
        end else if (nonempty) begin
            e = q.pop_front(); took = 1'b1; popped = 1'b1;
        end
        n_waddr = m_waddr; n_wdin = m_wdin; n_wena = 1'b0;
        if (took && e.addr != 0) begin
            n_wena = 1'b1; n_waddr = e.addr; n_wdin = e.data;
        end
        // Acceptance uses the occupancy before this cycle's pop.
        if (mv && (q.size() + (popped ? 1 : 0)) < DEPTH) q.push_back('{addr: ma, data: md});
        if (!nonempty || popped) m_scnt = 0;
        else if (m_scnt < LIMIT) m_scnt++;

        @(posedge clk);
        m_wena = n_wena; m_waddr = n_waddr; m_wdin = n_wdin;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic        cav, cmv;
        logic [4:0]  caa, cma;
        logic [31:0] cad, cmd;
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_wEna", {31'b0, wEna}, 32'd0);
        chk("rst_pending", pending, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'd1);
        @(negedge clk);

        // ALU only
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("alu_wAddr", {27'b0, wAddr}, 32'd5);
        chk("alu_wDin", wDin, 32'hDEADBEEF);
        chk("alu_wEna", {31'b0, wEna}, 32'd1);
        idle(2);

        // Memory only: five back-to-back offers, addresses 1..5
        for (int i = 1; i <= 5; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + i);
        idle(8);

        // Starvation under a saturated ALU
        n_stall = 0;
        step(1'b1, 5'd2, 32'hA0, 1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 14; i++) step(1'b1, 5'd3, 32'hB0 + i, 1'b0, 5'd0, 32'd0);
        chk("starve_stalls", n_stall, 32'd1);
        idle(2);

        // r0 filter
        n_wena = 0;
        step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5678);
        idle(3);
        chk("r0_no_wena", n_wena, 32'd0);

        // Two queued writes to r9 behind a busy ALU
        step(1'b1, 5'd4, 32'h1, 1'b1, 5'd9, 32'h91);
        step(1'b1, 5'd4, 32'h2, 1'b1, 5'd9, 32'h92);
        for (int i = 0; i < 3; i++) step(1'b1, 5'd4, 32'h3, 1'b0, 5'd0, 32'd0);
`ifdef WB_SCOREBOARD_EN
        chk("pending_r9", {31'b0, pending[9]}, 32'd1);
`else
        chk("pending_off", pending, 32'd0);
`endif
        idle(4);

        // Reset with three entries queued and the starvation counter at four
        step(1'b1, 5'd6, 32'h61, 1'b1, 5'd10, 32'hA1);
        step(1'b1, 5'd6, 32'h62, 1'b1, 5'd11, 32'hA2);
        step(1'b1, 5'd6, 32'h63, 1'b1, 5'd12, 32'hA3);
        step(1'b1, 5'd6, 32'h64, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd6, 32'h65, 1'b0, 5'd0, 32'd0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wEna", {31'b0, wEna}, 32'd0);
        chk("mid_rst_wAddr", {27'b0, wAddr}, 32'd0);
        chk("mid_rst_wDin", wDin, 32'd0);
        chk("mid_rst_pending", pending, 32'd0);
        chk("mid_rst_stall", {31'b0, alu_stall}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, mem_ready}, 32'd1);
        @(negedge clk);
        n_wena = 0;
        idle(4);
        chk("no_stale_write", n_wena, 32'd0);

        // Randomized traffic; stalled or refused offers are held as the pipeline would
        cav = 1'b0; caa = '0; cad = '0;
        cmv = 1'b0; cma = '0; cmd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!(cav && m_forced())) begin
                cav = ($urandom_range(0, 99) < 70);
                caa = 5'($urandom_range(0, 12));
                cad = $urandom;
            end
            if (!(cmv && q.size() >= DEPTH)) begin
                cmv = ($urandom_range(0, 99) < 40);
                cma = 5'($urandom_range(0, 12));
                cmd = $urandom;
            end
            step(cav, caa, cad, cmv, cma, cmd);
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
